// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter.
package mem_arb_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory handshake bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  p0_valid, p0_wr_rd, p0_ready, p0_err;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [WIDTH-1:0]      p0_wdata, p0_rdata;
  logic                  p1_valid, p1_wr_rd, p1_ready, p1_err;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [WIDTH-1:0]      p1_wdata, p1_rdata;
  logic                  m_valid, m_wr_rd, m_ready;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [WIDTH-1:0]      m_wdata, m_rdata;
  logic                  grant;

  // arbiter view
  modport slave (
    input  p0_valid, p0_wr_rd, p0_addr, p0_wdata,
    input  p1_valid, p1_wr_rd, p1_addr, p1_wdata,
    input  m_ready, m_rdata,
    output p0_ready, p0_rdata, p0_err,
    output p1_ready, p1_rdata, p1_err,
    output m_valid, m_wr_rd, m_addr, m_wdata, grant
  );

  // client + memory view
  modport master (
    output p0_valid, p0_wr_rd, p0_addr, p0_wdata,
    output p1_valid, p1_wr_rd, p1_addr, p1_wdata,
    output m_ready, m_rdata,
    input  p0_ready, p0_rdata, p0_err,
    input  p1_ready, p1_rdata, p1_err,
    input  m_valid, m_wr_rd, m_addr, m_wdata, grant
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick; a tie goes to the side that did not win last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           last_grant,
  output req_idx_t           win,
  output logic               any_req
);
  assign any_req = |req;
  assign win     = (&req) ? ~last_grant : req_idx_t'(req[1]);
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising two requesters onto one single-port memory.
// Optional watchdog abort on a stalled memory: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          res,
  mem_arbiter_if.slave  bus
);
  state_t   state, state_nxt;
  req_idx_t win, last_grant, gnt;
  logic     any_req, done, abort;
  logic     m_valid_q, m_wr_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic [WIDTH-1:0]      m_wdata_q;

  logic [NUM_REQ-1:0]                 req_vld, req_wr, rdy_q, err_q;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][WIDTH-1:0]      req_wdata, rdata_q;

  assign req_vld   = {bus.p1_valid, bus.p0_valid};
  assign req_wr    = {bus.p1_wr_rd, bus.p0_wr_rd};
  assign req_addr  = {bus.p1_addr,  bus.p0_addr};
  assign req_wdata = {bus.p1_wdata, bus.p0_wdata};

  // RELEASE is a dead cycle, so only IDLE consults the picker
  rr_arb2 u_rr (
    .req        (req_vld),
    .last_grant (last_grant),
    .win        (win),
    .any_req    (any_req)
  );

  assign done = (state == BUSY) && bus.m_ready;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge res) begin
    if (!res)                cnt <= '0;
    else if (state != BUSY)  cnt <= '0;
    else if (!bus.m_ready)   cnt <= cnt + 1'b1;
  end

  // m_ready in the expiry cycle is a normal completion
  assign abort = (state == BUSY) && !bus.m_ready && (cnt == CNT_W'(TIMEOUT - 1));
`else
  // no watchdog: BUSY waits for m_ready indefinitely
  assign abort = 1'b0 && (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)       state_nxt = BUSY;
      BUSY:    if (done || abort) state_nxt = RELEASE;
      RELEASE:                    state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      last_grant <= req_idx_t'(1);
      gnt        <= '0;
      m_valid_q  <= 1'b0;
      m_wr_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      rdy_q      <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      rdy_q <= '0;
      err_q <= '0;
      case (state)
        IDLE: if (any_req) begin
          gnt        <= win;
          last_grant <= win;
          m_valid_q  <= 1'b1;
          m_wr_q     <= req_wr[win];
          m_addr_q   <= req_addr[win];
          m_wdata_q  <= req_wdata[win];
        end
        BUSY: if (done || abort) begin
          m_valid_q <= 1'b0;
          m_wr_q    <= 1'b0;
          m_addr_q  <= '0;
          m_wdata_q <= '0;
          if (done) begin
            rdy_q[gnt] <= 1'b1;
            if (!m_wr_q) rdata_q[gnt] <= bus.m_rdata;
          end else begin
            err_q[gnt] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_valid  = m_valid_q;
  assign bus.m_wr_rd  = m_wr_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.grant    = gnt;
  assign bus.p0_ready = rdy_q[0];
  assign bus.p1_ready = rdy_q[1];
  assign bus.p0_err   = err_q[0];
  assign bus.p1_err   = err_q[1];
  assign bus.p0_rdata = rdata_q[0];
  assign bus.p1_rdata = rdata_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: request agents, memory model and a
// grant/data scoreboard derived from the round-robin rules.
module tb_mem_arbiter;
  localparam int W = 8, AW = 8, TO = 16;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();
  mem_arbiter #(.WIDTH(W), .DEPTH(256), .TIMEOUT(TO)) dut (.clk(clk), .res(res), .bus(bus));

  typedef struct { bit wr; logic [7:0] addr; logic [7:0] data; } req_t;

  req_t       rq0[$], rq1[$];
  req_t       cur[2];
  bit         pend[2];
  int         start_cyc[2], gap_cnt[2], done_cnt[2];
  logic [7:0] last_rdata[2];
  logic [7:0] mem[256], ref_mem[256];
  int checks = 0, failures = 0, cyc = 0, lat = 0;
  int fall_cyc = 0, rise_cyc = 0, err_cyc = -1, last_lat = 0;
  bit mem_stall = 0, rand_gap = 0, rand_lat = 0, model_last = 1, mv_prev = 0;
  int gseq[$], gaps[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(int s, bit wr, logic [7:0] a, logic [7:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.data = d;
    if (s == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  function automatic int outstanding();
    return int'(pend[0]) + int'(pend[1]) + rq0.size() + rq1.size();
  endfunction

  task automatic drive_req();
    bus.p0_valid = pend[0]; bus.p0_wr_rd = cur[0].wr; bus.p0_addr = cur[0].addr; bus.p0_wdata = cur[0].data;
    bus.p1_valid = pend[1]; bus.p1_wr_rd = cur[1].wr; bus.p1_addr = cur[1].addr; bus.p1_wdata = cur[1].data;
  endtask

  task automatic tick();
    bit fire, fw;
    logic [7:0] fa, fd;
    logic [1:0] vprev, rdy, er;
    logic [7:0] rd[2];
    int w;
    fire  = bus.m_valid && bus.m_ready;
    fw = bus.m_wr_rd; fa = bus.m_addr; fd = bus.m_wdata;
    vprev = {bus.p1_valid, bus.p0_valid};
    @(posedge clk); #1;
    cyc++;
    if (fire && fw) mem[fa] = fd;
    // transfer start: winner predicted from the valids seen in the arbitration cycle
    if (bus.m_valid && !mv_prev) begin
      w = (vprev == 2'b11) ? int'(!model_last) : int'(vprev[1]);
      chk("grant", bus.grant, w);
      chk("m_addr", bus.m_addr, cur[w].addr);
      chk("m_wr_rd", bus.m_wr_rd, cur[w].wr);
      if (cur[w].wr) chk("m_wdata", bus.m_wdata, cur[w].data);
      model_last = w[0];
      gseq.push_back(int'(bus.grant));
      gaps.push_back(cyc - fall_cyc);
      rise_cyc = cyc;
      last_lat = cyc - start_cyc[w];
      lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
    end
    if (!bus.m_valid && mv_prev) fall_cyc = cyc;
    mv_prev = bus.m_valid;
    rdy = {bus.p1_ready, bus.p0_ready};
    er  = {bus.p1_err, bus.p0_err};
    rd[0] = bus.p0_rdata; rd[1] = bus.p1_rdata;
    for (int s = 0; s < 2; s++) begin
      if (rdy[s]) begin
        chk("ready_pending", pend[s], 1);
        if (pend[s]) begin
          if (cur[s].wr) ref_mem[cur[s].addr] = cur[s].data;
          else chk("rdata", rd[s], ref_mem[cur[s].addr]);
          last_rdata[s] = rd[s];
          done_cnt[s]++;
          pend[s] = 0;
          gap_cnt[s] = rand_gap ? int'($urandom_range(0, 3)) : 0;
        end
      end
      if (er[s]) begin
`ifdef MEM_ARB_TIMEOUT_EN
        chk("err_pending", pend[s], 1);
        err_cyc = cyc;
        pend[s] = 0;
`else
        chk("err_tied0", er[s], 0);
`endif
      end
    end
    // requesters present the next queued item, possibly in the RELEASE cycle
    for (int s = 0; s < 2; s++) begin
      if (!pend[s]) begin
        if (gap_cnt[s] > 0) gap_cnt[s]--;
        else if (s == 0 && rq0.size() > 0) begin cur[0] = rq0.pop_front(); pend[0] = 1; start_cyc[0] = cyc; end
        else if (s == 1 && rq1.size() > 0) begin cur[1] = rq1.pop_front(); pend[1] = 1; start_cyc[1] = cyc; end
      end
    end
    drive_req();
    if (bus.m_valid && !mem_stall && lat == 0) begin
      bus.m_ready = 1'b1; bus.m_rdata = mem[bus.m_addr];
    end else begin
      bus.m_ready = 1'b0; bus.m_rdata = 8'($urandom);
      if (bus.m_valid && lat > 0) lat--;
    end
  endtask

  task automatic drain(string tag, int max);
    int n = 0;
    while (outstanding() > 0 && n < max) begin tick(); n++; end
    tick(); tick();
    chk(tag, outstanding(), 0);
  endtask

  task automatic wait_mvalid(string tag);
    int n = 0;
    while (!bus.m_valid && n < 20) begin tick(); n++; end
    chk(tag, bus.m_valid, 1);
  endtask

  task automatic do_reset();
    #2 res = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_grant", bus.grant, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_ready", {bus.p1_ready, bus.p0_ready}, 0);
    chk("rst_err", {bus.p1_err, bus.p0_err}, 0);
    rq0.delete(); rq1.delete(); gseq.delete(); gaps.delete();
    pend[0] = 0; pend[1] = 0; gap_cnt[0] = 0; gap_cnt[1] = 0;
    model_last = 1; mv_prev = 0; lat = 0;
    drive_req();
    bus.m_ready = 1'b0;
    tick(); tick();
    res = 1'b1;
  endtask

  initial begin
    int n, d0, rc;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    cur[0] = '{0, 0, 0}; cur[1] = '{0, 0, 0};
    drive_req();
    bus.m_ready = 1'b0; bus.m_rdata = '0;
    #3 do_reset();

    // single write then read-back on p0
    push(0, 1, 8'h01, 8'h5A);
    drain("wr_drain", 50);
    chk("arb_latency", last_lat, 1);
    push(0, 0, 8'h01, 8'h00);
    drain("rd_drain", 50);
    chk("p0_rd_5a", last_rdata[0], 8'h5A);

    // simultaneous first requests: p0 then p1
    do_reset();
    push(0, 1, 8'h10, 8'hA1);
    push(1, 1, 8'h11, 8'hB2);
    drain("tie_drain", 50);
    chk("tie_count", gseq.size(), 2);
    if (gseq.size() == 2) begin
      chk("tie_first", gseq[0], 0);
      chk("tie_second", gseq[1], 1);
    end

    // both saturated: strict alternation
    gseq.delete();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'($urandom), 8'($urandom), 8'($urandom));
      push(1, 1'($urandom), 8'($urandom), 8'($urandom));
    end
    d0 = done_cnt[0];
    drain("alt_drain", 200);
    chk("alt_count", gseq.size(), 8);
    for (int i = 0; i < gseq.size() && i < 8; i++) chk("alternate", gseq[i], i % 2);
    chk("alt_p0_done", done_cnt[0] - d0, 4);

    // p1 alone, back-to-back reads: m_valid low for RELEASE + IDLE only
    gaps.delete();
    push(1, 0, 8'hFE, 0); push(1, 0, 8'h7F, 0); push(1, 0, 8'h80, 0);
    drain("b2b_drain", 100);
    chk("b2b_count", gaps.size(), 3);
    if (gaps.size() == 3) begin
      chk("b2b_gap1", gaps[1], 2);
      chk("b2b_gap2", gaps[2], 2);
    end
    chk("b2b_last", last_rdata[1], ref_mem[8'h80]);

    // randomised traffic with random gaps and memory latency
    rand_gap = 1; rand_lat = 1;
    for (int i = 0; i < 30; i++) begin
      push(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
      push(1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
    end
    drain("rand_drain", 3000);
    rand_gap = 0; rand_lat = 0;

    // reset while p0 owns a stalled transfer; p0 priority restored
    mem_stall = 1;
    push(0, 0, 8'h20, 0);
    wait_mvalid("stall_start");
    do_reset();
    mem_stall = 0;
    push(0, 1, 8'h21, 8'h33);
    push(1, 1, 8'h22, 8'h44);
    drain("post_rst_drain", 50);
    if (gseq.size() > 0) chk("post_rst_p0_first", gseq[0], 0);
    else chk("post_rst_grants", gseq.size(), 2);

    // stalled memory
    mem_stall = 1;
    d0 = done_cnt[0];
    push(0, 0, 8'h30, 0);
    wait_mvalid("to_start");
    rc = rise_cyc;
`ifdef MEM_ARB_TIMEOUT_EN
    err_cyc = -1;
    n = 0;
    while (err_cyc < 0 && n < 40) begin tick(); n++; end
    chk("err_delay", err_cyc - rc, TO);
    chk("to_no_ready", done_cnt[0] - d0, 0);
    chk("to_m_valid_low", bus.m_valid, 0);
    mem_stall = 0;
    drain("to_drain", 50);
`else
    n = rc;
    repeat (40) tick();
    chk("stall_m_valid", bus.m_valid, 1);
    chk("stall_no_ready", done_cnt[0] - d0, 0);
    mem_stall = 0;
    drain("stall_drain", 50);
    chk("stall_done", done_cnt[0] - d0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
